seg7_scan_mux: RTL and testbench

//  Time-multiplexed driver for the Basys3 4-digit common-anode 7-seg display.

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/seg7_glyph_rom.sv | 17 +
 rtl/seg7_scan_mux.sv | 142 ++++++++++++++
 tb/tb_seg7_scan_mux.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan driver.
// Glyph table is active-low {g,f,e,d,c,b,a}.
`default_nettype none

package seg7_pkg;

  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_ALL = 7'h00;

  typedef enum logic [1:0] {
    S0 = 2'd0,  // digit A, an[3]
    S1 = 2'd1,  // digit B, an[2]
    S2 = 2'd2,  // digit C, an[1]
    S3 = 2'd3   // digit D, an[0]
  } scan_state_t;

  // 0-9 digits, A b C d E letters for the message stages, F dark
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h7F
  };

  function automatic logic [3:0] an_onehot_low(input scan_state_t s);
    logic [3:0] sel;
    sel = 4'b1000 >> s;
    return ~sel;
  endfunction

  function automatic logic blank_for(input scan_state_t s, input logic [3:0] mask);
    return mask[2'd3 - s];
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_glyph_rom.sv
// Combinational glyph decoder: 4-bit code to active-low segment pattern.
`default_nettype none

module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH[code];
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode driver: frame-latched shadow inputs, one digit
// per slot, blanking guard at each slot start, registered active-low outputs.
`default_nettype none

module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic [3:0] blank,
  input  logic       lamp_test,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          slot_end;
  logic          in_guard;

  scan_state_t   state;
  scan_state_t   state_next;

  logic [3:0]    shadow_code [4];
  logic [3:0]    shadow_blank;

  logic [3:0]    cur_code;
  logic          cur_blank;
  logic [6:0]    glyph_seg;

  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  assign slot_end = (div_cnt == DIV_LAST);

  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (div_cnt < CW'(GUARD));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S0;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (slot_end) begin
      case (state)
        S0:      state_next = S1;
        S1:      state_next = S2;
        S2:      state_next = S3;
        S3:      state_next = S0;
        default: state_next = S0;
      endcase
    end
  end

  // Inputs are sampled only at the frame boundary so a digit never tears mid-frame
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_code  <= '{default: 4'h0};
      shadow_blank <= AN_OFF;
      frame_tick   <= 1'b0;
    end else begin
      frame_tick <= slot_end && (state == S3);
      if (slot_end && (state == S3)) begin
        shadow_code[0] <= A;
        shadow_code[1] <= B;
        shadow_code[2] <= C;
        shadow_code[3] <= D;
        shadow_blank   <= blank;
      end
    end
  end

  assign cur_code  = shadow_code[state];
  assign cur_blank = blank_for(state, shadow_blank);

  seg7_glyph_rom u_glyph_rom (
    .code (cur_code),
    .seg  (glyph_seg)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!in_guard && !cur_blank) begin
      an_d = an_onehot_low(state);
      if (lamp_test) begin
        seg_d = SEG_ALL;
        dp_d  = 1'b0;
      end else begin
        seg_d = glyph_seg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with REFRESH_DIV=8, GUARD=2.
`default_nettype none

module tb_seg7_scan_mux;

  logic       clk;
  logic       reset;
  logic [3:0] A, B, C, D;
  logic [3:0] blank;
  logic       lamp_test;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int compared;
  int mismatched;

  seg7_scan_mux #(
    .REFRESH_DIV (8),
    .GUARD       (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .blank      (blank),
    .lamp_test  (lamp_test),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                     input logic dp_e, input logic ft_e, input bit full);
    compared++;
    assert (an === an_e) else begin
      mismatched++;
      $error("FAIL %s an: observed %b expected %b", tag, an, an_e);
    end
    compared++;
    assert (frame_tick === ft_e) else begin
      mismatched++;
      $error("FAIL %s frame_tick: observed %b expected %b", tag, frame_tick, ft_e);
    end
    if (full) begin
      compared++;
      assert (seg === seg_e) else begin
        mismatched++;
        $error("FAIL %s seg: observed %h expected %h", tag, seg, seg_e);
      end
      compared++;
      assert (dp === dp_e) else begin
        mismatched++;
        $error("FAIL %s dp: observed %b expected %b", tag, dp, dp_e);
      end
    end
  endtask

  // One 32-edge frame; on[s]=1 means slot s is driven. Optionally changes A after edge chg_k.
  task automatic run_frame(input string name, input logic [3:0] on, input logic [6:0] s0,
                           input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3,
                           input logic lamp, input int chg_k, input logic [3:0] chg_a);
    logic [6:0] segs [4];
    logic [3:0] sel;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int k = 1; k <= 32; k++) begin
      int slot;
      int ph;
      string tag;
      tick();
      slot = (k - 1) / 8;
      ph   = (k - 1) % 8;
      tag  = $sformatf("%s k%0d", name, k);
      if (ph < 2) begin
        chk(tag, 4'hF, 7'h7F, 1'b1, k == 32, 1'b1);
      end else if (on[slot]) begin
        sel = 4'b1000 >> slot;
        chk(tag, ~sel, lamp ? 7'h00 : segs[slot], ~lamp, k == 32, 1'b1);
      end else begin
        chk(tag, 4'hF, 7'h7F, 1'b1, k == 32, 1'b0);
      end
      if (k == chg_k) A = chg_a;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // reset held with random inputs
    reset     = 1'b0;
    A         = 4'($urandom);
    B         = 4'($urandom);
    C         = 4'($urandom);
    D         = 4'($urandom);
    blank     = 4'($urandom);
    lamp_test = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("reset c%0d", i), 4'hF, 7'h7F, 1'b1, 1'b0, 1'b1);
    end

    // release; display stays dark until first frame latch at edge 32
    A = 4'h1; B = 4'h2; C = 4'h3; D = 4'h4;
    blank = 4'b0000; lamp_test = 1'b0;
    reset = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("startup k%0d", k), 4'hF, 7'h7F, 1'b1, k == 32, 1'b0);
    end

    // frame showing 1,2,3,4; next inputs staged for the following latch
    A = 4'h7; B = 4'hA; C = 4'h4; D = 4'hC; blank = 4'b1000;
    run_frame("f1234", 4'b1111, 7'h79, 7'h24, 7'h30, 7'h19, 1'b0, 0, 4'h0);

    // leftmost digit blanked; mid-frame changes must not show until next frame
    blank = 4'b0000; A = 4'h8;
    run_frame("fblank", 4'b1110, 7'h7F, 7'h08, 7'h19, 7'h46, 1'b0, 14, 4'h9);

    // value of A present at the latch edge (9) wins over earlier 8
    blank = 4'b0010;
    run_frame("fnewA", 4'b1111, 7'h10, 7'h08, 7'h19, 7'h46, 1'b0, 0, 4'h0);

    // lamp test with digit C blanked
    lamp_test = 1'b1;
    A = 4'h3; B = 4'h2; C = 4'h1; D = 4'h0; blank = 4'b0000;
    run_frame("flamp", 4'b1011, 7'h00, 7'h00, 7'h00, 7'h00, 1'b1, 0, 4'h0);

    // mid-slot2 reset pulse
    lamp_test = 1'b0;
    for (int k = 0; k < 19; k++) tick();
    reset = 1'b0;
    tick();
    chk("midreset", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("restart k%0d", k), 4'hF, 7'h7F, 1'b1, k == 32, 1'b0);
    end
    run_frame("f3210", 4'b1111, 7'h30, 7'h24, 7'h79, 7'h40, 1'b0, 0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
